// File: rtl/rr_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter_if
//  Purpose  : Request/grant bundle between N_REQ requesters and the
//             round-robin arbiter guarding a shared datapath resource.
//  Signals  : enable    - permits new grants (requester side drives)
//             req       - request vector, bit i = requester i
//             done      - current owner releases the resource
//             gnt       - one-hot grant, zero when idle
//             gnt_idx   - binary index of the owner (valid with gnt_valid)
//             gnt_valid - a grant is active
//             timeout   - single-cycle pulse on a forced revoke
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface rr_grant_arbiter_if #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
);
   logic             enable;
   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output enable, req, done,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  enable, req, done,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter
//  Purpose  : Round-robin arbiter sharing one resource among N_REQ
//             requesters. A grant is held until the owner signals done,
//             withdraws its request, or the hold timeout expires; each
//             release is followed by one dead cycle before re-arbitration.
//  Ports    : clk - clock, all state on the rising edge
//             rst - synchronous active-high reset
//             bus - rr_grant_arbiter_if.slave (enable/req/done in,
//                   gnt/gnt_idx/gnt_valid/timeout out, all registered)
//  Params   : N_REQ (power of 2, 2..8), IDX_W = log2(N_REQ),
//             MAX_HOLD (cycles a grant may be held, 0 = no timeout)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 4
) (
   input  wire                  clk,
   input  wire                  rst,
   rr_grant_arbiter_if.slave    bus
);

   // Counter only needs to reach MAX_HOLD-1; keep at least one bit.
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t            r_state,     w_state_nxt;
   logic [IDX_W-1:0]  r_ptr,       w_ptr_nxt;
   logic [HOLD_W-1:0] r_hold_cnt,  w_hold_nxt;
   logic [N_REQ-1:0]  r_gnt,       w_gnt_nxt;
   logic [IDX_W-1:0]  r_gnt_idx,   w_idx_nxt;
   logic              r_gnt_valid, w_valid_nxt;
   logic              r_timeout,   w_timeout_nxt;

   logic              w_found;
   logic [IDX_W-1:0]  w_winner;
   logic [IDX_W-1:0]  w_scan;
   logic              w_timeout_hit;
   logic              w_owner_req;

   // Rotating priority scan: ptr has highest priority, then ptr+1, ...
   // N_REQ is a power of two so the index add wraps for free.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_scan = r_ptr + IDX_W'(k);
         if (!w_found && bus.req[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan;
         end
      end
   end

   assign w_timeout_hit = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_LAST);
   assign w_owner_req   = bus.req[r_gnt_idx];

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold_cnt;
      w_gnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_valid_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable && w_found) begin
               w_state_nxt = S_GRANT;
               w_gnt_nxt   = N_REQ'(1) << w_winner;
               w_idx_nxt   = w_winner;
               w_valid_nxt = 1'b1;
               w_hold_nxt  = '0;
            end
         end
         S_GRANT: begin
            if (bus.done || !w_owner_req || w_timeout_hit) begin
               w_state_nxt   = S_RELEASE;
               w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
               w_hold_nxt    = '0;
               // Pulse only when the timeout is the sole reason for release.
               w_timeout_nxt = !bus.done && w_owner_req && w_timeout_hit;
            end else begin
               w_gnt_nxt   = r_gnt;
               w_idx_nxt   = r_gnt_idx;
               w_valid_nxt = 1'b1;
               // Saturate so a disabled timeout can never wrap the counter.
               if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                  w_hold_nxt = r_hold_cnt + HOLD_W'(1);
               end
            end
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_hold_cnt  <= '0;
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_idx   <= w_idx_nxt;
         r_gnt_valid <= w_valid_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_gnt_idx;
   assign bus.gnt_valid = r_gnt_valid;
   assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_arbiter
//  Purpose  : Directed self-checking bench for rr_grant_arbiter
//             (N_REQ=8, IDX_W=3, MAX_HOLD=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   rr_grant_arbiter_if #(.N_REQ(8), .IDX_W(3)) bus ();

   rr_grant_arbiter #(
      .N_REQ    (8),
      .IDX_W    (3),
      .MAX_HOLD (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled and inputs driven on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                          input logic v, input logic t);
      chk({tag, ".gnt"},     32'(bus.gnt),       32'(g));
      chk({tag, ".gnt_idx"}, 32'(bus.gnt_idx),   32'(idx));
      chk({tag, ".valid"},   32'(bus.gnt_valid), 32'(v));
      chk({tag, ".timeout"}, 32'(bus.timeout),   32'(t));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.req    = '0;
      bus.done   = 1'b0;

      // Reset held 3 cycles: everything zero
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      end
      chk("rst.ptr", 32'(dut.r_ptr), 32'd0);

      // Single requester 2, release by done
      rst        = 1'b0;
      bus.enable = 1'b1;
      bus.req    = 8'h04;
      tick();
      chk_out("single", 8'h04, 3'd2, 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_out("single.rel", 8'h00, 3'd0, 1'b0, 1'b0);
      bus.done = 1'b0;
      bus.req  = 8'h00;
      tick();
      chk_out("single.idle", 8'h00, 3'd0, 1'b0, 1'b0);
      chk("single.ptr", 32'(dut.r_ptr), 32'd3);

      // All requesting, done each grant: order 0..7 then wrap to 0
      do_reset();
      bus.req = 8'hFF;
      tick();
      for (int g = 0; g < 9; g++) begin
         chk($sformatf("rr%0d", g), 32'(bus.gnt), 32'(8'h01 << (g % 8)));
         chk($sformatf("rr%0d.idx", g), 32'(bus.gnt_idx), 32'(g % 8));
         bus.done = 1'b1;
         tick();
         chk($sformatf("rr%0d.gap1", g), 32'(bus.gnt), 32'd0);
         bus.done = 1'b0;
         tick();
         chk($sformatf("rr%0d.gap2", g), 32'(bus.gnt), 32'd0);
         tick();
      end
      // Grant 1 is now active; reset mid-grant drops it at the next edge
      chk_out("pre_rst", 8'h02, 3'd1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst     = 1'b0;
      bus.req = 8'h00;
      tick();

      // Timeout: requester 4 holds for exactly 4 cycles
      bus.req = 8'h10;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_out($sformatf("hold%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
      end
      tick();
      chk_out("tmo", 8'h00, 3'd0, 1'b0, 1'b1);
      bus.req = 8'h00;
      tick();
      chk_out("tmo.after", 8'h00, 3'd0, 1'b0, 1'b0);

      // done on the 4th held cycle wins over timeout
      bus.req = 8'h10;
      tick();
      tick();
      tick();
      tick();
      chk_out("done4.held", 8'h10, 3'd4, 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_out("done4.rel", 8'h00, 3'd0, 1'b0, 1'b0);
      bus.done = 1'b0;
      bus.req  = 8'h00;
      tick();

      // Owner withdraws mid-grant: no timeout
      bus.req = 8'h20;
      tick();
      chk_out("drop.gnt", 8'h20, 3'd5, 1'b1, 1'b0);
      bus.req = 8'h00;
      tick();
      chk_out("drop.rel", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();

      // enable=0 blocks new grants
      bus.enable = 1'b0;
      bus.req    = 8'h81;
      tick();
      chk("noen1", 32'(bus.gnt), 32'd0);
      tick();
      chk("noen2", 32'(bus.gnt), 32'd0);
      // ptr=6 after owner 5 -> requester 7 wins over 0
      bus.enable = 1'b1;
      tick();
      chk_out("en.gnt", 8'h80, 3'd7, 1'b1, 1'b0);
      bus.enable = 1'b0;
      tick();
      chk("en_low1", 32'(bus.gnt), 32'h80);
      tick();
      chk("en_low2", 32'(bus.gnt), 32'h80);
      bus.done = 1'b1;
      tick();
      chk_out("en_low.rel", 8'h00, 3'd0, 1'b0, 1'b0);
      chk("wrap.ptr", 32'(dut.r_ptr), 32'd0);
      bus.done   = 1'b0;
      bus.enable = 1'b1;
      tick();
      tick();
      chk_out("wrap.gnt", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
